// File: rtl/elevator_scan_controller.sv
// ---------------------------------------------------------------------------
// elevator_scan_controller
//
// SCAN-order elevator controller. Floor requests are collected at any time
// into a pending bitmap. The car keeps travelling in its current direction
// while requests remain ahead of it, then reverses. Every served floor gets
// a door-open phase.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   req_valid  in   request strobe, one request per cycle
//   req_floor  in   requested floor index
//   req_err    out  one-cycle pulse: last request was out of range
//   cur_floor  out  floor the car is at (or last passed)
//   dir_up     out  current / last travel direction, 1 = up
//   moving     out  car is travelling between floors
//   door_open  out  door is open
//   finish     out  one-cycle pulse on arrival at / opening for a requested floor
//   pending    out  outstanding-request bitmap, one bit per floor
//
// Optional build macro ELEVATOR_ESTOP_EN adds:
//   estop      in   emergency stop, active high, synchronous
//   halted     out  high while estop is applied
// ---------------------------------------------------------------------------
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 6,
  parameter int FLOOR_W       = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
  output logic                  halted,
`endif
  output logic                  req_err,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  finish,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W:0]   NF          = (FLOOR_W + 1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
  logic                    dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0]   pending_q, pending_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    finish_q, finish_d;
  logic                    req_err_q, req_err_d;

  logic                    halt;
`ifdef ELEVATOR_ESTOP_EN
  assign halt   = estop;
  assign halted = estop;
`else
  assign halt   = 1'b0;
`endif

  logic                    req_ok, req_here, arrive_hit;
  logic                    any_above, any_below, ahead, behind;
  logic [NUM_FLOORS-1:0]   above_mask, below_mask;
  logic [FLOOR_W-1:0]      next_floor;

  // Request decode and SCAN look-ahead on the registered bitmap.
  always_comb begin
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (FLOOR_W'(i) > cur_floor_q);
      below_mask[i] = (FLOOR_W'(i) < cur_floor_q);
    end
    req_ok     = req_valid && ({1'b0, req_floor} < NF);
    req_here   = req_ok && (req_floor == cur_floor_q);
    any_above  = |(pending_q & above_mask);
    any_below  = |(pending_q & below_mask);
    ahead      = dir_up_q ? any_above : any_below;
    behind     = dir_up_q ? any_below : any_above;
    next_floor = dir_up_q ? (cur_floor_q + FLOOR_W'(1)) : (cur_floor_q - FLOOR_W'(1));
    // A request for the floor being reached this edge is served by the arrival.
    arrive_hit = pending_q[next_floor] || (req_ok && (req_floor == next_floor));
  end

  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    finish_d    = 1'b0;
    req_err_d   = req_valid && !req_ok;

    // A request for the floor the car is standing at never becomes pending;
    // it is served (IDLE) or extends the door (DOOR) instead.
    if (req_ok && !(req_here && (state_q != S_MOVE))) begin
      pending_d[req_floor] = 1'b1;
    end

    if (!halt) begin
      unique case (state_q)
        S_IDLE: begin
          if (req_here) begin
            state_d  = S_DOOR;
            cnt_d    = '0;
            finish_d = 1'b1;
          end else if (|pending_q) begin
            state_d = S_MOVE;
            cnt_d   = '0;
            if (!ahead) dir_up_d = !dir_up_q;
          end
        end
        S_MOVE: begin
          if (cnt_q == TRAVEL_LAST) begin
            cur_floor_d = next_floor;
            cnt_d       = '0;
            if (arrive_hit) begin
              pending_d[next_floor] = 1'b0;
              finish_d              = 1'b1;
              state_d               = S_DOOR;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DOOR: begin
          if (req_here) begin
            cnt_d = '0;
          end else if (cnt_q == DOOR_LAST) begin
            cnt_d = '0;
            if (ahead) begin
              state_d = S_MOVE;
            end else if (behind) begin
              dir_up_d = !dir_up_q;
              state_d  = S_MOVE;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cur_floor_q <= '0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      cnt_q       <= '0;
      finish_q    <= 1'b0;
      req_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      finish_q    <= finish_d;
      req_err_q   <= req_err_d;
    end
  end

  assign cur_floor = cur_floor_q;
  assign dir_up    = dir_up_q;
  assign pending   = pending_q;
  assign finish    = finish_q;
  assign req_err   = req_err_q;
  assign moving    = (state_q == S_MOVE) && !halt;
  assign door_open = (state_q == S_DOOR);

`ifndef SYNTHESIS
  // The car must stay inside the shaft and never step past either end.
  a_floor_bounds: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, cur_floor_q} < NF) &&
    !((state_q == S_MOVE) && !halt && (cnt_q == TRAVEL_LAST) &&
      (dir_up_q ? (cur_floor_q == TOP_FLOOR) : (cur_floor_q == '0))));
`endif

endmodule

// File: tb/tb_elevator_scan_controller.sv
module tb_elevator_scan_controller;
  localparam int NF = 6;
  localparam int FW = 3;
  localparam int TC = 4;
  localparam int DC = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic [FW-1:0] req_floor = '0;
  logic          req_err, dir_up, moving, door_open, finish;
  logic [FW-1:0] cur_floor;
  logic [NF-1:0] pending;
`ifdef ELEVATOR_ESTOP_EN
  logic          estop = 1'b0;
  logic          halted;
`endif

  elevator_scan_controller #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop), .halted(halted),
`endif
    .req_err(req_err), .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving),
    .door_open(door_open), .finish(finish), .pending(pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n++;

  // Behavioural model: mode 0 idle, 1 travelling, 2 door open.
  // mleft = cycles left in the current travel leg / door phase.
  bit mp[NF];
  int mfloor, mdir, mmode, mleft;
  bit mfin, merr;

  task automatic model_reset();
    for (int i = 0; i < NF; i++) mp[i] = 1'b0;
    mfloor = 0; mdir = 1; mmode = 0; mleft = 0; mfin = 1'b0; merr = 1'b0;
  endtask

  function automatic bit m_any_toward(int d);
    for (int f = 0; f < NF; f++)
      if (mp[f] && ((f - mfloor) * d > 0)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_any_set();
    for (int f = 0; f < NF; f++) if (mp[f]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(bit v, int f);
    bit np[NF];
    bit ok, here, ahead, behind;
    ok     = v && (f < NF);
    merr   = v && !ok;
    mfin   = 1'b0;
    here   = ok && (f == mfloor);
    ahead  = m_any_toward(mdir);
    behind = m_any_toward(-mdir);
    np = mp;
    if (ok && !(here && mmode != 1)) np[f] = 1'b1;
    case (mmode)
      0: begin
        if (here) begin
          mmode = 2; mleft = DC; mfin = 1'b1;
        end else if (m_any_set()) begin
          mmode = 1; mleft = TC;
          if (!ahead) mdir = -mdir;
        end
      end
      1: begin
        mleft--;
        if (mleft == 0) begin
          mfloor += mdir;
          mleft = TC;
          if ((mfloor >= 0 && mfloor < NF && mp[mfloor]) || (ok && f == mfloor)) begin
            np[mfloor] = 1'b0; mfin = 1'b1; mmode = 2; mleft = DC;
          end
        end
      end
      default: begin
        if (here) mleft = DC;
        else begin
          mleft--;
          if (mleft == 0) begin
            if (ahead) begin mmode = 1; mleft = TC; end
            else if (behind) begin mdir = -mdir; mmode = 1; mleft = TC; end
            else mmode = 0;
          end
        end
      end
    endcase
    mp = np;
  endtask

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(req_valid, int'(req_floor));
  end
  always @(negedge rst) model_reset();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [NF-1:0] ep;
    for (int i = 0; i < NF; i++) ep[i] = mp[i];
    checks++;
    if ({cur_floor, dir_up, moving, door_open, finish, req_err, pending} !==
        {FW'(mfloor), (mdir > 0), (mmode == 1), (mmode == 2), mfin, merr, ep}) begin
      errors++;
      $display("FAIL cycle_cmp edge %0d: got floor=%0d dir=%0b mov=%0b door=%0b fin=%0b err=%0b pend=%b, expected floor=%0d dir=%0b mov=%0b door=%0b fin=%0b err=%0b pend=%b",
               edge_n, cur_floor, dir_up, moving, door_open, finish, req_err, pending,
               mfloor, (mdir > 0), (mmode == 1), (mmode == 2), mfin, merr, ep);
    end
  end

  // Event log for the directed literal checks.
  int fin_edges[$], fin_floors[$], fin_dirs[$];
  int door_cnt = 0, err_cnt = 0, err_edge = -1;
  always @(negedge clk) begin
    if (finish) begin
      fin_edges.push_back(edge_n);
      fin_floors.push_back(int'(cur_floor));
      fin_dirs.push_back(int'(dir_up));
    end
    if (door_open) door_cnt++;
    if (req_err) begin err_cnt++; err_edge = edge_n; end
  end

  task automatic clear_log();
    fin_edges.delete(); fin_floors.delete(); fin_dirs.delete();
    door_cnt = 0; err_cnt = 0; err_edge = -1;
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(bit v, int f);
    @(negedge clk);
    #2;
    req_valid = v;
    req_floor = FW'(f);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    bit found;
    int rate;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cur_floor", int'(cur_floor), 0);
    chk("rst_dir_up", int'(dir_up), 1);
    chk("rst_pending", int'(pending), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_door_open", int'(door_open), 0);
    chk("rst_finish", int'(finish), 0);
    chk("rst_req_err", int'(req_err), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Request floor 3 from floor 0: finish after edge a+1+3*4.
    clear_log();
    drive(1'b1, 3);
    a = edge_n + 1;
    idle(25);
    chk("s1_fin_count", fin_edges.size(), 1);
    chk("s1_fin_edge", (fin_edges.size() > 0) ? fin_edges[0] : -1, a + 13);
    chk("s1_fin_floor", (fin_floors.size() > 0) ? fin_floors[0] : -1, 3);
    chk("s1_door_cycles", door_cnt, 6);
    chk("s1_cur_floor", int'(cur_floor), 3);
    chk("s1_pending", int'(pending), 0);
    chk("s1_idle", int'({moving, door_open}), 0);
    chk("s1_model_floor", mfloor, 3);

    // Request own floor while idle, then re-request at door cycle 4.
    clear_log();
    drive(1'b1, 3);
    a = edge_n + 1;
    drive(1'b0, 0);
    drive(1'b0, 0);
    drive(1'b1, 3);
    idle(15);
    chk("s2_fin_count", fin_edges.size(), 1);
    chk("s2_fin_edge", (fin_edges.size() > 0) ? fin_edges[0] : -1, a);
    chk("s2_door_cycles", door_cnt, 9);
    chk("s2_pending", int'(pending), 0);

    // From 3: request 5 then 1 -> serve 5 going up, then 1 going down.
    clear_log();
    drive(1'b1, 5);
    a = edge_n + 1;
    drive(1'b1, 1);
    idle(45);
    chk("s3_fin_count", fin_edges.size(), 2);
    chk("s3_fin0_floor", (fin_floors.size() > 0) ? fin_floors[0] : -1, 5);
    chk("s3_fin0_edge", (fin_edges.size() > 0) ? fin_edges[0] : -1, a + 9);
    chk("s3_fin0_dir", (fin_dirs.size() > 0) ? fin_dirs[0] : -1, 1);
    chk("s3_fin1_floor", (fin_floors.size() > 1) ? fin_floors[1] : -1, 1);
    chk("s3_fin1_edge", (fin_edges.size() > 1) ? fin_edges[1] : -1, a + 31);
    chk("s3_fin1_dir", (fin_dirs.size() > 1) ? fin_dirs[1] : -1, 0);

    // Out-of-range request.
    clear_log();
    drive(1'b1, 7);
    a = edge_n + 1;
    idle(3);
    chk("s4_err_count", err_cnt, 1);
    chk("s4_err_edge", err_edge, a);
    chk("s4_pending", int'(pending), 0);
    chk("s4_idle", int'({moving, door_open}), 0);
    chk("s4_cur_floor", int'(cur_floor), 1);

    // Reset while travelling between floors 2 and 3.
    drive(1'b1, 4);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      drive(1'b0, 0);
      if (cur_floor == 3'd2 && moving) found = 1'b1;
    end
    chk("s5_reached_floor2", int'(found), 1);
    drive(1'b0, 0);
    rst = 1'b0;
    #1;
    chk("s5_cur_floor", int'(cur_floor), 0);
    chk("s5_moving", int'(moving), 0);
    chk("s5_pending", int'(pending), 0);
    chk("s5_dir_up", int'(dir_up), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    idle(3);

    // Randomised traffic, busy then sparse, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rate = (i < 1500) ? 25 : 6;
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        #2 rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end else begin
        drive($urandom_range(0, 99) < rate, int'($urandom_range(0, 7)));
      end
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
